// File: rtl/digest_checker_pkg.sv
// Shared types and constants for the digest checker: FSM states, error codes
// and the digest geometry.
package digest_chk_pkg;

  localparam int WORD_W       = 64;
  localparam int DIGEST_WORDS = 4;
  localparam int CNT_W        = 3;
  localparam int IDX_W        = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_COLL = 2'd2,
    ERR_TMO  = 2'd3
  } err_e;

endpackage

// File: rtl/digest_checker_if.sv
// Host/stream-side bus of the digest checker: control pulses, digest stream,
// expected-word load port, readback and verdict.
interface digest_checker_if;
  import digest_chk_pkg::*;

  logic             start;
  logic             clear;
  logic             sha2_valid;
  logic             sha3_valid;
  word_t            data_in;
  logic             exp_we;
  logic             exp_sel;
  logic [IDX_W-1:0] exp_idx;
  word_t            exp_data;
  logic             rd_sel;
  logic [IDX_W-1:0] rd_idx;
  word_t            rd_data;
  logic             busy;
  logic             done;
  logic             sha2_match;
  logic             sha3_match;
  logic             auth_pass;
  logic [1:0]       err_code;

  modport master (
    output start, clear, sha2_valid, sha3_valid, data_in,
           exp_we, exp_sel, exp_idx, exp_data, rd_sel, rd_idx,
    input  rd_data, busy, done, sha2_match, sha3_match, auth_pass, err_code
  );

  modport slave (
    input  start, clear, sha2_valid, sha3_valid, data_in,
           exp_we, exp_sel, exp_idx, exp_data, rd_sel, rd_idx,
    output rd_data, busy, done, sha2_match, sha3_match, auth_pass, err_code
  );

endinterface

// File: rtl/digest_checker_bank.sv
// One digest lane (SHA2 or SHA3): expected and captured words, the word
// counter, the running match flag and the accept/overflow decision.
module digest_bank
  import digest_chk_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             clear,
  input  logic             arm,
  input  logic             exp_we,
  input  logic [IDX_W-1:0] exp_idx,
  input  word_t            exp_data,
  input  logic             word_valid,
  input  word_t            data_in,
  input  logic [IDX_W-1:0] rd_idx,
  output word_t            rd_data,
  output logic             accept,
  output logic             overflow,
  output logic             full,
  output logic             match
);

  word_t            exp_mem [DIGEST_WORDS];
  word_t            cap_mem [DIGEST_WORDS];
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] wr_idx;

  assign full     = (cnt == CNT_W'(DIGEST_WORDS));
  assign accept   = word_valid && !full;
  assign overflow = word_valid && full;
  assign wr_idx   = cnt[IDX_W-1:0];
  assign rd_data  = cap_mem[rd_idx];

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // the compare below must see the old cnt, not the incremented one.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt   <= '0;
      match <= 1'b0;
      // NOTE: both word arrays are reset because readback after srst must be
      // zero; this keeps them in flops rather than a RAM macro.
      for (int i = 0; i < DIGEST_WORDS; i++) begin
        exp_mem[i] <= '0;
        cap_mem[i] <= '0;
      end
    end else begin
      if (exp_we) exp_mem[exp_idx] <= exp_data;
      if (clear) begin
        cnt   <= '0;
        match <= 1'b0;
      end else if (arm) begin
        cnt   <= '0;
        match <= 1'b1;
      end else if (accept) begin
        cap_mem[wr_idx] <= data_in;
        cnt             <= cnt + CNT_W'(1);
        if (data_in != exp_mem[wr_idx]) match <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/digest_checker.sv
// Digest checker top: FSM, collision detection, idle timeout and verdict
// outputs around two digest_bank lanes.
module digest_checker
  import digest_chk_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input logic             clk,
  input logic             srst,
  digest_checker_if.slave bus
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  state_e           state;
  err_e             err_q;
  err_e             err_new;
  logic             busy_q;
  logic             done_q;
  logic [TMO_W-1:0] tmo_cnt;

  logic  collecting, collision, arm, v2, v3;
  logic  acc2, acc3, ovf2, ovf3, full2, full3, m2, m3;
  logic  any_accept, tmo_hit, finished;
  word_t rd2, rd3;

  // Words are only taken while collecting and before an error is latched.
  assign collecting = (state == COLLECT) && (err_q == ERR_NONE);
  assign collision  = collecting && bus.sha2_valid && bus.sha3_valid;
  assign v2         = collecting && bus.sha2_valid && !bus.sha3_valid;
  assign v3         = collecting && bus.sha3_valid && !bus.sha2_valid;
  assign arm        = bus.start && !bus.clear && (state != COLLECT);
  assign any_accept = acc2 || acc3;
  assign tmo_hit    = (TIMEOUT != 0) && !any_accept && (tmo_cnt == TMO_LAST);
  assign finished   = (err_q != ERR_NONE) || (full2 && full3);

  digest_bank u_sha2 (
    .clk        (clk),
    .srst       (srst),
    .clear      (bus.clear),
    .arm        (arm),
    .exp_we     (bus.exp_we && !bus.exp_sel && (state == IDLE)),
    .exp_idx    (bus.exp_idx),
    .exp_data   (bus.exp_data),
    .word_valid (v2),
    .data_in    (bus.data_in),
    .rd_idx     (bus.rd_idx),
    .rd_data    (rd2),
    .accept     (acc2),
    .overflow   (ovf2),
    .full       (full2),
    .match      (m2)
  );

  digest_bank u_sha3 (
    .clk        (clk),
    .srst       (srst),
    .clear      (bus.clear),
    .arm        (arm),
    .exp_we     (bus.exp_we && bus.exp_sel && (state == IDLE)),
    .exp_idx    (bus.exp_idx),
    .exp_data   (bus.exp_data),
    .word_valid (v3),
    .data_in    (bus.data_in),
    .rd_idx     (bus.rd_idx),
    .rd_data    (rd3),
    .accept     (acc3),
    .overflow   (ovf3),
    .full       (full3),
    .match      (m3)
  );

  // NOTE: err_new gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    err_new = ERR_NONE;
    if (collision)         err_new = ERR_COLL;
    else if (ovf2 || ovf3) err_new = ERR_OVF;
    else if (tmo_hit)      err_new = ERR_TMO;
  end

  always_ff @(posedge clk) begin
    if (srst || bus.clear) begin
      state   <= IDLE;
      err_q   <= ERR_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= COLLECT;
            err_q   <= ERR_NONE;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            tmo_cnt <= '0;
          end
        end
        COLLECT: begin
          if (finished) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            if (err_new != ERR_NONE) err_q <= err_new;
            tmo_cnt <= any_accept ? '0 : tmo_cnt + TMO_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_data    = bus.rd_sel ? rd3 : rd2;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sha2_match = done_q && m2;
  assign bus.sha3_match = done_q && m3;
  assign bus.auth_pass  = done_q && m2 && m3 && (err_q == ERR_NONE);
  assign bus.err_code   = err_q;

endmodule

// File: tb/tb_digest_checker.sv
// Self-checking bench for digest_checker: directed scenarios plus randomized
// digest streams scored against a transaction-level model.
module tb_digest_checker;
  import digest_chk_pkg::*;

  localparam int TMO = 8;

  logic clk;
  logic srst;
  digest_checker_if bus ();

  digest_checker #(.TIMEOUT(TMO)) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model of the programmed and captured digests.
  word_t mexp2 [4];
  word_t mexp3 [4];
  word_t mcap2 [4];
  word_t mcap3 [4];

  // Per-cycle stimulus for one check, entry 0 is the first cycle after start.
  logic  q_v2 [$];
  logic  q_v3 [$];
  word_t q_d  [$];

  function automatic word_t rnd_word();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.clear      = 1'b0;
    bus.sha2_valid = 1'b0;
    bus.sha3_valid = 1'b0;
    bus.data_in    = '0;
    bus.exp_we     = 1'b0;
  endtask

  task automatic push(input logic v2, input logic v3, input word_t d);
    q_v2.push_back(v2);
    q_v3.push_back(v3);
    q_d.push_back(d);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic load_random();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) begin
        word_t w;
        w = rnd_word();
        bus.exp_we   = 1'b1;
        bus.exp_sel  = s[0];
        bus.exp_idx  = k[1:0];
        bus.exp_data = w;
        if (s == 0) mexp2[k] = w;
        else        mexp3[k] = w;
        step();
      end
    end
    bus.exp_we = 1'b0;
  endtask

  task automatic check_readback(input string name);
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) begin
        word_t exp_w;
        bus.rd_sel = s[0];
        bus.rd_idx = k[1:0];
        #1;
        exp_w = (s == 0) ? mcap2[k] : mcap3[k];
        checks++;
        if (bus.rd_data !== exp_w) begin
          errors++;
          $display("FAIL %s readback sel=%0d idx=%0d got=%h exp=%h",
                   name, s, k, bus.rd_data, exp_w);
        end
      end
    end
  endtask

  // Model the queued stream from the rules, then drive it and compare.
  task automatic run_check(input string name);
    int   c2, c3, idle, ev, got, n, err;
    bit   m2, m3;
    logic v2, v3;
    word_t d;
    c2 = 0; c3 = 0; idle = 0; ev = -1; err = 0; m2 = 1; m3 = 1;
    n = q_v2.size();
    for (int i = 0; i < 64 && ev < 0; i++) begin
      v2 = (i < n) ? q_v2[i] : 1'b0;
      v3 = (i < n) ? q_v3[i] : 1'b0;
      d  = (i < n) ? q_d[i]  : '0;
      if (v2 && v3) err = 2;
      else if (v2) begin
        if (c2 < 4) begin
          if (d != mexp2[c2]) m2 = 0;
          mcap2[c2] = d; c2++; idle = 0;
        end else err = 1;
      end else if (v3) begin
        if (c3 < 4) begin
          if (d != mexp3[c3]) m3 = 0;
          mcap3[c3] = d; c3++; idle = 0;
        end else err = 1;
      end else begin
        idle++;
        if (idle == TMO) err = 3;
      end
      if (err != 0 || (c2 == 4 && c3 == 4)) ev = i;
    end

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start got=%b exp=1", name, bus.busy);
    end
    got = -1;
    for (int i = 0; i < 80 && got < 0; i++) begin
      bus.sha2_valid = (i < n) ? q_v2[i] : 1'b0;
      bus.sha3_valid = (i < n) ? q_v3[i] : 1'b0;
      bus.data_in    = (i < n) ? q_d[i]  : '0;
      step();
      if (bus.done === 1'b1) got = i;
    end
    idle_inputs();

    checks++;
    if (got != ev + 1) begin
      errors++;
      $display("FAIL %s done_cycle got=%0d exp=%0d", name, got, ev + 1);
    end
    checks++;
    if (bus.err_code !== 2'(err)) begin
      errors++;
      $display("FAIL %s err_code got=%0d exp=%0d", name, bus.err_code, err);
    end
    checks++;
    if (bus.sha2_match !== m2 || bus.sha3_match !== m3) begin
      errors++;
      $display("FAIL %s match got=%b%b exp=%b%b", name,
               bus.sha2_match, bus.sha3_match, m2, m3);
    end
    checks++;
    if (bus.auth_pass !== (m2 && m3 && err == 0) || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s auth_pass/busy got=%b/%b exp=%b/0", name,
               bus.auth_pass, bus.busy, m2 && m3 && err == 0);
    end
    check_readback(name);
    q_v2.delete();
    q_v3.delete();
    q_d.delete();
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.busy, bus.done, bus.sha2_match, bus.sha3_match,
         bus.auth_pass, bus.err_code} !== 7'b0) begin
      errors++;
      $display("FAIL %s outputs got=%b%b%b%b%b err=%0d exp=all zero", name,
               bus.busy, bus.done, bus.sha2_match, bus.sha3_match,
               bus.auth_pass, bus.err_code);
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    step();
    step();
    srst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mexp2[k] = '0; mexp3[k] = '0; mcap2[k] = '0; mcap3[k] = '0;
    end
    check_all_zero("reset");
    check_readback("reset");
  endtask

  task automatic test_match_sha2_first();
    do_clear();
    load_random();
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, mexp2[k]);
    push(1'b0, 1'b0, '0);
    push(1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) push(1'b0, 1'b1, mexp3[k]);
    run_check("sha2_first_match");
  endtask

  task automatic test_mismatch_sha3_first();
    word_t bad;
    do_clear();
    load_random();
    bad = mexp3[2] ^ 64'h1;
    for (int k = 0; k < 4; k++) push(1'b0, 1'b1, (k == 2) ? bad : mexp3[k]);
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, mexp2[k]);
    run_check("sha3_first_mismatch");
    bus.rd_sel = 1'b1;
    bus.rd_idx = 2'd2;
    #1;
    checks++;
    if (bus.rd_data !== bad) begin
      errors++;
      $display("FAIL sha3_word2_readback got=%h exp=%h", bus.rd_data, bad);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, mexp2[k]);
    push(1'b1, 1'b0, rnd_word());
    run_check("overflow");
  endtask

  task automatic test_collision();
    push(1'b1, 1'b1, rnd_word());
    run_check("collision");
  endtask

  task automatic test_timeout();
    push(1'b1, 1'b0, mexp2[0]);
    run_check("timeout");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        push(1'b1, 1'b0, mexp2[k]);
        push(1'b0, 1'b1, mexp3[k]);
      end
      run_check("back_to_back");
    end
  endtask

  task automatic test_clear();
    word_t w0, w1;
    do_clear();
    load_random();
    w0 = rnd_word();
    w1 = mexp2[1];
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.sha2_valid = 1'b1;
    bus.data_in = w0;
    step();
    bus.data_in = w1;
    step();
    idle_inputs();
    mcap2[0] = w0;
    mcap2[1] = w1;
    bus.clear = 1'b1;
    bus.start = 1'b1;
    step();
    idle_inputs();
    check_all_zero("clear_beats_start");
    step();
    check_all_zero("clear_stays_idle");
    check_readback("clear_keeps_capture");
  endtask

  task automatic test_srst_mid_collect();
    do_clear();
    load_random();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.sha2_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.data_in = mexp2[k];
      step();
    end
    idle_inputs();
    test_reset();
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, '0);
    for (int k = 0; k < 4; k++) push(1'b0, 1'b1, '0);
    run_check("zero_after_srst");
    checks++;
    if (bus.auth_pass !== 1'b1) begin
      errors++;
      $display("FAIL zero_digest_pass got=%b exp=1", bus.auth_pass);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int i2, i3;
      if (it % 3 == 0) begin
        do_clear();
        load_random();
      end
      i2 = 0; i3 = 0;
      while (i2 < 4 || i3 < 4) begin
        bit    pick3;
        word_t w;
        for (int g = $urandom_range(0, 3); g > 0; g--) push(1'b0, 1'b0, rnd_word());
        if ($urandom_range(0, 29) == 0) push(1'b1, 1'b1, rnd_word());
        pick3 = (i2 == 4) || (i3 < 4 && $urandom_range(0, 1) == 1);
        w = pick3 ? mexp3[i3] : mexp2[i2];
        if ($urandom_range(0, 15) == 0) w = w ^ (64'd1 << $urandom_range(0, 63));
        push(!pick3, pick3, w);
        if (pick3) i3++;
        else       i2++;
      end
      if ($urandom_range(0, 4) == 0) push($urandom_range(0, 1) == 1, 1'b0, rnd_word());
      run_check("random");
    end
  endtask

  initial begin
    srst       = 1'b1;
    bus.rd_sel = 1'b0;
    bus.rd_idx = '0;
    bus.exp_sel  = 1'b0;
    bus.exp_idx  = '0;
    bus.exp_data = '0;
    idle_inputs();
    test_reset();
    test_match_sha2_first();
    test_mismatch_sha3_first();
    test_overflow();
    test_collision();
    test_timeout();
    test_back_to_back();
    test_clear();
    test_srst_mid_collect();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
